ahb_sram_ctrl: RTL and testbench

AHB-Lite slave that converts bus transfers into single-port accesses on the `sram` macro (active-low chip select, write enable, registered read output `dout_reg`). Sits directly upstream of `sram`: drives its `csen_n/we/addr/din` and returns its `dout_reg` on `hrdata`. Word (32-bit) transfers only. Zero-wait writes, zero-wait reads, one wait state only on a read that collides with a write data phase; illegal accesses get a two-cycle ERROR.

---
 rtl/ahb_sram_ctrl.sv | 67 ++++++
 tb/tb_ahb_sram_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-Lite word slave driving a single-port SRAM with registered read data.
// Reads issue in the address phase; a read landing on a write data phase waits one cycle.
module ahb_sram_ctrl #(
    parameter int HADDR_W    = 32,
    parameter int DATA_W     = 32,
    parameter int WIDTH      = 10,
    parameter int DEPTH      = 64,
    parameter int WIDTH_ADDR = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hsel,
    input  logic [HADDR_W-1:0]    haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [DATA_W-1:0]     hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DATA_W-1:0]     hrdata,
    output logic                  sram_csen_n,
    output logic                  sram_we,
    output logic [WIDTH_ADDR-1:0] sram_addr,
    output logic [WIDTH-1:0]      sram_din,
    input  logic [WIDTH-1:0]      sram_dout_reg
);
    typedef enum logic [2:0] {IDLE, WR_DATA, RD_DATA, RD_WAIT, RD_LATE, ERR1, ERR2} state_t;

    state_t                state_q, state_d;
    logic [WIDTH_ADDR-1:0] addr_q, addr_d;
    logic [HADDR_W-3:0]    word_idx;
    logic                  ready, acc, illegal, rd_now, port_busy, unused_ok;

    assign word_idx  = haddr[HADDR_W-1:2];
    assign illegal   = hsize != 3'b010 || haddr[1:0] != 2'b00 || word_idx >= (HADDR_W-2)'(DEPTH);
    assign ready     = state_q != RD_WAIT && state_q != ERR1;
    assign acc       = hsel && htrans[1] && hready && ready;
    assign rd_now    = acc && !hwrite && !illegal && state_q != WR_DATA;
    assign port_busy = state_q == WR_DATA || state_q == RD_WAIT;
    assign unused_ok = ^{htrans[0], hwdata >> WIDTH};

    always_comb begin
        state_d = acc ? (illegal ? ERR1 : hwrite ? WR_DATA : state_q == WR_DATA ? RD_WAIT : RD_DATA)
                : state_q == RD_WAIT ? RD_LATE : state_q == ERR1 ? ERR2 : IDLE;
        addr_d  = acc ? haddr[WIDTH_ADDR+1:2] : addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // reset overrides every output combinationally so a pending write cannot reach the SRAM
    assign hreadyout   = rst || ready;
    assign hresp       = !rst && (state_q == ERR1 || state_q == ERR2);
    assign hrdata      = (!rst && (state_q == RD_DATA || state_q == RD_LATE)) ? DATA_W'(sram_dout_reg) : '0;
    assign sram_we     = !rst && state_q == WR_DATA;
    assign sram_csen_n = rst || !(port_busy || rd_now);
    assign sram_addr   = rst ? '0 : rd_now ? haddr[WIDTH_ADDR+1:2] : port_busy ? addr_q : '0;
    assign sram_din    = sram_we ? hwdata[WIDTH-1:0] : '0;
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: scoreboard bench; driver queues expected data-phase responses, monitor checks them.
module tb_ahb_sram_ctrl;
    localparam int K_IDLE = 0, K_WR = 1, K_RD = 2, K_ERR = 3;

    typedef struct {
        int          kind;
        int          waits;
        logic [31:0] rdata;
        logic [5:0]  waddr;
        logic [9:0]  wdata;
    } exp_t;

    logic        clk = 1'b0, rst, hsel, hwrite, hready, hreadyout, hresp;
    logic        sram_csen_n, sram_we, fill;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [5:0]  sram_addr;
    logic [9:0]  sram_din, dout_reg;
    logic [9:0]  mem [64];
    logic [9:0]  ref_mem [64];
    bit          ad_rd, prev_wr;
    int          n_cmp = 0, n_bad = 0;
    exp_t        q[$];

    assign hready = hreadyout;

    ahb_sram_ctrl dut (
        .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hresp(hresp),
        .hrdata(hrdata), .sram_csen_n(sram_csen_n), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout_reg(dout_reg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 64; i++) mem[i] <= 10'(i * 97 + 13);
            dout_reg <= '0;
        end else if (!sram_csen_n) begin
            if (sram_we) mem[sram_addr] <= sram_din;
            else dout_reg <= mem[sram_addr];
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic xfer(bit sel, logic [1:0] tr, bit wr, logic [2:0] sz, logic [31:0] a, logic [31:0] d);
        exp_t e;
        int   n;
        bit   act, legal;
        hsel   = sel;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        act    = sel && tr[1];
        legal  = sz == 3'b010 && a[1:0] == 2'b00 && a < 32'd256;
        ad_rd  = act && !wr && legal;
        n = 0;
        @(negedge clk);
        while (!hreadyout && n < 8) begin
            n++;
            @(negedge clk);
        end
        if (!hreadyout) chk("accept_timeout", 32'(hreadyout), 32'd1);
        @(posedge clk);
        e.kind  = !act ? K_IDLE : !legal ? K_ERR : wr ? K_WR : K_RD;
        e.waits = (e.kind == K_ERR || (e.kind == K_RD && prev_wr)) ? 1 : 0;
        e.waddr = a[7:2];
        e.wdata = d[9:0];
        e.rdata = e.kind == K_RD ? 32'(ref_mem[a[7:2]]) : 32'd0;
        if (e.kind == K_WR) ref_mem[a[7:2]] = d[9:0];
        prev_wr = e.kind == K_WR;
        q.push_back(e);
        #1 hwdata = d;
    endtask

    initial begin : monitor
        int   wc;
        bit   stall;
        exp_t e;
        wc = 0;
        forever begin
            @(negedge clk);
            if (!rst && q.size() > 0) begin
                e     = q[0];
                stall = wc < e.waits;
                chk("hreadyout", 32'(hreadyout), 32'(!stall));
                chk("hresp", 32'(hresp), 32'(e.kind == K_ERR));
                chk("hrdata", hrdata, (!stall && e.kind == K_RD) ? e.rdata : 32'd0);
                chk("sram_we", 32'(sram_we), 32'(!stall && e.kind == K_WR));
                chk("sram_csen_n", 32'(sram_csen_n),
                    32'(!(stall ? e.kind == K_RD : (e.kind == K_WR || ad_rd))));
                if (!stall && e.kind == K_WR) begin
                    chk("wr_addr", 32'(sram_addr), 32'(e.waddr));
                    chk("wr_din", 32'(sram_din), 32'(e.wdata));
                end
                if (hreadyout || wc >= 4) begin
                    void'(q.pop_front());
                    wc = 0;
                end else wc++;
            end
        end
    end

    initial begin
        rst = 1'b1; fill = 1'b1; hsel = 1'b1; htrans = 2'd2; hwrite = 1'b0; hsize = 3'b010;
        haddr = '0; hwdata = '0; ad_rd = 1'b0; prev_wr = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 10'(i * 97 + 13);
        @(posedge clk);
        #1 fill = 1'b0; hwrite = 1'b1;
        @(negedge clk);
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_csen_n", 32'(sram_csen_n), 32'd1);
        chk("rst_we", 32'(sram_we), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_din", 32'(sram_din), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        xfer(1'b0, 2'd0, 1'b0, 3'b010, 32'h0, 32'h0);
        // write to 0x20 is accepted, then reset lands in its data phase and must drop it
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h20; ad_rd = 1'b0;
        @(posedge clk);
        #1 hwdata = 32'h155; rst = 1'b1; hsel = 1'b0; htrans = 2'd0;
        repeat (2) begin
            @(negedge clk);
            chk("rstw_csen_n", 32'(sram_csen_n), 32'd1);
            chk("rstw_we", 32'(sram_we), 32'd0);
            chk("rstw_hreadyout", 32'(hreadyout), 32'd1);
            chk("rstw_hresp", 32'(hresp), 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        prev_wr = 1'b0;
        chk("rstw_mem", 32'(mem[8]), 32'(ref_mem[8]));
        xfer(1'b1, 2'd2, 1'b1, 3'b010, 32'h08, 32'h3A5);
        xfer(1'b1, 2'd0, 1'b0, 3'b010, 32'h0, 32'h0);
        xfer(1'b1, 2'd2, 1'b0, 3'b010, 32'h08, 32'h0);
        xfer(1'b1, 2'd2, 1'b1, 3'b010, 32'h10, 32'h111);
        xfer(1'b1, 2'd2, 1'b0, 3'b010, 32'h10, 32'h0);
        for (int i = 0; i < 3; i++) xfer(1'b1, 2'd3, 1'b1, 3'b010, 32'(i * 4), 32'(i + 1));
        xfer(1'b1, 2'd0, 1'b0, 3'b010, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) xfer(1'b1, 2'd3, 1'b0, 3'b010, 32'(i * 4), 32'h0);
        xfer(1'b1, 2'd2, 1'b0, 3'b010, 32'h100, 32'h0);
        xfer(1'b1, 2'd2, 1'b0, 3'b001, 32'h0, 32'h0);
        xfer(1'b1, 2'd2, 1'b0, 3'b010, 32'h02, 32'h0);
        xfer(1'b1, 2'd1, 1'b1, 3'b010, 32'h04, 32'h3FF);
        xfer(1'b0, 2'd2, 1'b1, 3'b010, 32'h04, 32'h3FF);
        xfer(1'b1, 2'd2, 1'b0, 3'b010, 32'h20, 32'h0);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom_range(0, 15) == 0 ? 32'($urandom_range(0, 300))
              : $urandom_range(0, 1) == 0 ? 32'($urandom_range(0, 3)) << 2 : 32'($urandom_range(0, 63)) << 2;
            xfer($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0 ? 3'($urandom_range(0, 7)) : 3'b010, a, $urandom);
        end
        repeat (3) xfer(1'b0, 2'd0, 1'b0, 3'b010, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
